rv_sdram_bridge: RTL and testbench
==================================

Name: rv_sdram_bridge

Overview:
- Upstream feeder for the SDRAM controller's RISC-V port (bank 2, 2MB, 16-bit toggle-handshake interface).
- Accepts 32-bit native valid/ready requests from the RISC-V softcore and splits each into one or two 16-bit SDRAM accesses.
- Returns the assembled 32-bit read data and a single-cycle ready to the core.

Parameters:
- ADDR_BITS, 21: byte-address width of the RV memory space; mem_addr bits above ADDR_BITS-1 are ignored (decode happens upstream).
- SKIP_EMPTY_HALF, 1: if 1, a write issues no SDRAM access for a 16-bit half whose two strobe bits are 0.

Ports:
- clk  in  1  main clock (21.477MHz), shared with the SDRAM controller.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  core request valid; held until mem_ready.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 4'b0000 means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- rv_addr  out  20  SDRAM halfword address [20:1].
- rv_din  out  16  SDRAM write data.
- rv_ds  out  2  byte enables {hi,lo}.
- rv_we  out  1  write when 1.
- rv_req  out  1  request toggle.
- rv_req_ack  in  1  controller ack toggle; equals rv_req when idle or done.
- rv_dout  in  16  SDRAM read data; valid on the clk after rv_req_ack becomes equal to rv_req.

Behaviour:
- Reset values:
  - rv_req=0, mem_ready=0, mem_rdata=0.
  - rv_addr=0, rv_din=0, rv_ds=0, rv_we=0.
  - State=SYNC.
- Reset mid-operation:
  - Abandons any access; no mem_ready is produced for it.
  - The controller is reset in the same domain.
- SYNC: wait until rv_req_ack==rv_req, then go to IDLE.
  - Covers acks still in flight after reset.
  - No request is accepted in SYNC.
- IDLE, on mem_valid=1:
  - Latch addr, wdata and wstrb; set half=LO.
  - If this is a write and SKIP_EMPTY_HALF=1 and wstrb[1:0]==0, set half=HI instead.
  - Drive the port for that half and toggle rv_req in the same cycle.
  - Go to WAIT.
- Port drive for each half:
  - rv_addr = {addr[ADDR_BITS-1:2], half}, with half 0=LO, 1=HI.
  - Read: rv_we=0, rv_ds=2'b11.
  - Write: rv_we=1, rv_ds = wstrb[1:0] (LO) or wstrb[3:2] (HI), rv_din = the matching wdata half.
- WAIT: stay until rv_req_ack==rv_req, then go to CAPT.
  - Port outputs are held constant from the toggle through CAPT.
- CAPT:
  - Read: latch rv_dout into the lo or hi half of the rdata register.
  - If half==LO and the HI half is needed: set half=HI, drive the port, toggle rv_req, go to WAIT (same cycle).
  - Otherwise go to RESP.
  - HI is needed for every read, and for writes unless SKIP_EMPTY_HALF=1 and wstrb[3:2]==0.
- RESP:
  - mem_ready=1 for exactly one cycle; mem_rdata = assembled word (read) or holds its previous value (write).
  - mem_valid is ignored in this cycle; go to IDLE.
  - A new request can be accepted on the next cycle.
- Minimum latency, with ack arriving 1 cycle after the toggle:
  - Read: accept T0, ack T1, CAPT T2 (issues HI), ack T3, CAPT T4, mem_ready T5.
  - Single-half write: mem_ready at T3.
- Exactly one outstanding toggle at any time; rv_req never toggles while rv_req!=rv_req_ack.
- mem_valid dropping before mem_ready (protocol violation): the access still completes and mem_ready still pulses.
- Address wrap: addr[ADDR_BITS-1:2] is all ones for the top word; no carry between halves (HI = same word, half=1).

Decomposition:
- State enum (SYNC, IDLE, WAIT, CAPT, RESP) and the HALF_LO/HALF_HI constants go in configPackage, alongside the SDRAM widths.
- No sub-module; the toggle handshake is a few registers inside this block.

Test Plan:
- Read from mem_addr=0x0000_1234 with preloaded mem_rv[0x91A]=0xBEEF and [0x91B]=0xCAFE, ack 1 cycle after toggle:
  - Expect rv_addr 0x0091A then 0x0091B and two rv_req toggles.
  - Expect mem_ready at T5 with mem_rdata=0xCAFEBEEF.
- Write 0x11223344 to 0x100, wstrb=4'b1111:
  - Expect two writes: [0x80]=0x3344 with ds=11, then [0x81]=0x1122 with ds=11.
  - Expect mem_ready at T5.
- Write wstrb=4'b0100 to 0x200, SKIP_EMPTY_HALF=1:
  - Expect a single access at rv_addr=0x101 with ds=2'b01, rv_din=wdata[31:16].
  - Expect mem_ready at T3.
- Ack delayed 7 cycles per half:
  - Expect rv_addr/din/ds/we stable throughout and no second toggle before the ack.
  - Expect mem_ready 1 cycle after the second CAPT; total latency 17 cycles.
- Reset asserted while in WAIT for the HI half, with rv_req_ack lagging 3 cycles after reset releases:
  - Expect no mem_ready and rv_req=0.
  - Expect no new toggle until rv_req_ack==0; the next read then completes correctly.
- Back-to-back reads with mem_valid held high across RESP:
  - Expect the second request accepted in the cycle after the mem_ready pulse.
  - Expect no double issue and distinct correct mem_rdata for each read.

Source files
------------

// File: rtl/rv_sdram_bridge_pkg.sv
// Shared constants for the RISC-V to SDRAM bridge: port widths, FSM state
// encodings and half-word selectors.
package configPackage;
    localparam int RV_AW = 20;
    localparam int RV_DW = 16;
    localparam int MEM_W = 32;

    localparam logic [2:0] ST_SYNC = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_CAPT = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;
endpackage

// File: rtl/rv_sdram_bridge.sv
// Splits 32-bit core requests into one or two 16-bit accesses on the SDRAM
// controller's toggle-handshake port and returns the assembled word.
module rv_sdram_bridge
    import configPackage::*;
#(
    parameter int ADDR_BITS       = 21,
    parameter bit SKIP_EMPTY_HALF = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [MEM_W-1:0] mem_addr,
    input  logic [MEM_W-1:0] mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [MEM_W-1:0] mem_rdata,
    output logic [RV_AW-1:0] rv_addr,
    output logic [RV_DW-1:0] rv_din,
    output logic [1:0]       rv_ds,
    output logic             rv_we,
    output logic             rv_req,
    input  logic             rv_req_ack,
    input  logic [RV_DW-1:0] rv_dout,
    output logic [2:0]       o_dbg_state
);
    // Core side: mem_valid is held until a one-cycle mem_ready; SDRAM side: a
    // request is outstanding while rv_req != rv_req_ack, and only one at a time.
    logic [2:0]           r_state;
    logic [ADDR_BITS-3:0] r_word;
    logic [MEM_W-1:0]     r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_half;
    logic [RV_DW-1:0]     r_rdata_lo;

    logic w_is_wr;
    logic w_start_half;
    logic w_wr_latched;
    logic w_need_hi;
    logic w_ack_eq;
    logic w_unused_addr;

    assign w_is_wr       = |mem_wstrb;
    assign w_start_half  = (w_is_wr && SKIP_EMPTY_HALF && (mem_wstrb[1:0] == 2'b00)) ? HALF_HI : HALF_LO;
    assign w_wr_latched  = |r_wstrb;
    assign w_need_hi     = !w_wr_latched || !SKIP_EMPTY_HALF || (r_wstrb[3:2] != 2'b00);
    assign w_ack_eq      = (rv_req_ack == rv_req);
    assign w_unused_addr = ^{mem_addr[MEM_W-1:ADDR_BITS], mem_addr[1:0]};
    assign o_dbg_state   = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SYNC;
            r_word     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_half     <= HALF_LO;
            r_rdata_lo <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            rv_addr    <= '0;
            rv_din     <= '0;
            rv_ds      <= '0;
            rv_we      <= 1'b0;
            rv_req     <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            case (r_state)
                // Absorbs an ack that was still in flight when reset hit.
                ST_SYNC: if (w_ack_eq) r_state <= ST_IDLE;
                ST_IDLE: begin
                    if (mem_valid) begin
                        r_word  <= mem_addr[ADDR_BITS-1:2];
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                        r_half  <= w_start_half;
                        rv_addr <= RV_AW'({mem_addr[ADDR_BITS-1:2], w_start_half});
                        rv_we   <= w_is_wr;
                        rv_ds   <= w_is_wr ? (w_start_half ? mem_wstrb[3:2] : mem_wstrb[1:0]) : 2'b11;
                        rv_din  <= w_start_half ? mem_wdata[31:16] : mem_wdata[15:0];
                        rv_req  <= ~rv_req;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: if (w_ack_eq) r_state <= ST_CAPT;
                ST_CAPT: begin
                    if (!w_wr_latched) begin
                        if (r_half == HALF_LO) r_rdata_lo <= rv_dout;
                        else                   mem_rdata  <= {rv_dout, r_rdata_lo};
                    end
                    if (r_half == HALF_LO && w_need_hi) begin
                        r_half  <= HALF_HI;
                        rv_addr <= RV_AW'({r_word, HALF_HI});
                        rv_ds   <= w_wr_latched ? r_wstrb[3:2] : 2'b11;
                        rv_din  <= r_wdata[31:16];
                        rv_req  <= ~rv_req;
                        r_state <= ST_WAIT;
                    end else begin
                        mem_ready <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_sdram_bridge.sv
// Directed bench for rv_sdram_bridge with a behavioural toggle-handshake
// SDRAM controller and scoreboarded SDRAM accesses and core responses.
module tb_rv_sdram_bridge;
    import configPackage::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [19:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_we;
    logic        rv_req;
    logic        rv_req_ack = 1'b0;
    logic [15:0] rv_dout = 16'h0;
    logic [2:0]  o_dbg_state;

    rv_sdram_bridge #(.ADDR_BITS(21), .SKIP_EMPTY_HALF(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds),
        .rv_we(rv_we), .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [38:0] exp_acc_q[$];   // {we, addr, ds, din}
    logic [63:0] exp_rsp_q[$];   // {latency, t0, rdata}
    logic [15:0] mem_rv[logic [19:0]];

    int   ack_delay   = 1;
    bit   ctl_manual  = 1'b0;
    logic ctl_ack_val = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] acc(input logic we, input logic [19:0] a,
                                        input logic [1:0] ds, input logic [15:0] din);
        return {we, a, ds, din};
    endfunction

    // ---------------- SDRAM controller model + port checks ----------------
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_reset = 1'b1;
    logic [38:0] snap = '0;
    logic [38:0] act_acc;
    logic [15:0] wtmp;
    int          ctl_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!reset && !prev_reset) begin
            if (rv_req != prev_req) begin
                chk("toggle_while_outstanding", {63'd0, prev_req ^ prev_ack}, 64'd0);
                snap = {rv_we, rv_addr, rv_ds, rv_din};
            end else if (o_dbg_state == ST_WAIT || o_dbg_state == ST_CAPT) begin
                chk("port_stable", {rv_we, rv_addr, rv_ds, rv_din}, snap);
            end
        end
        if (ctl_manual) begin
            rv_req_ack = ctl_ack_val;
            ctl_cnt    = 0;
        end else if (rv_req != rv_req_ack) begin
            ctl_cnt++;
            if (ctl_cnt >= ack_delay) begin
                act_acc = {rv_we, rv_addr, rv_ds, rv_we ? rv_din : 16'h0};
                if (exp_acc_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL acc_unexpected: got %0h expected none", act_acc);
                end else begin
                    chk("sdram_access", act_acc, exp_acc_q.pop_front());
                end
                if (rv_we) begin
                    wtmp = mem_rv.exists(rv_addr) ? mem_rv[rv_addr] : 16'h0;
                    if (rv_ds[0]) wtmp[7:0]  = rv_din[7:0];
                    if (rv_ds[1]) wtmp[15:8] = rv_din[15:8];
                    mem_rv[rv_addr] = wtmp;
                end else begin
                    rv_dout = mem_rv.exists(rv_addr) ? mem_rv[rv_addr] : 16'h0;
                end
                rv_req_ack = rv_req;
                ctl_cnt    = 0;
            end
        end
        prev_req   = rv_req;
        prev_ack   = rv_req_ack;
        prev_reset = reset;
    end

    // ---------------- response monitor ----------------
    logic [63:0] exp_rsp;
    int          lat;

    always @(posedge clk) begin
        #1;
        if (mem_ready) begin
            if (exp_rsp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got mem_ready rdata %0h expected none", mem_rdata);
            end else begin
                exp_rsp = exp_rsp_q.pop_front();
                lat     = cyc - int'(exp_rsp[47:32]);
                chk("mem_rdata", mem_rdata, exp_rsp[31:0]);
                chk("latency", 64'(lat), exp_rsp[63:48]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_rsp(input bit keep);
        bit got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (mem_ready) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL rsp_timeout: got no mem_ready expected one within 100 cycles");
        end
        if (!keep) mem_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int n_acc, input logic [38:0] a0, input logic [38:0] a1,
                         input logic [31:0] rdata, input int exp_lat,
                         input bit b2b, input bit keep, input bit wait_done);
        if (!b2b) begin
            @(posedge clk); #1;
        end
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        exp_acc_q.push_back(a0);
        if (n_acc == 2) exp_acc_q.push_back(a1);
        exp_rsp_q.push_back({16'(exp_lat), 16'(b2b ? cyc + 1 : cyc), rdata});
        if (wait_done) wait_rsp(keep);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        mem_rv[20'h0091A] = 16'hBEEF;
        mem_rv[20'h0091B] = 16'hCAFE;
        mem_rv[20'h02000] = 16'h1357;
        mem_rv[20'h02001] = 16'h2468;
        mem_rv[20'hFFFFE] = 16'h0F0F;
        mem_rv[20'hFFFFF] = 16'hF0F0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", rv_req, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_addr", rv_addr, 0);
        chk("rst_din", rv_din, 0);
        chk("rst_ds", rv_ds, 0);
        chk("rst_we", rv_we, 0);
        chk("rst_state", o_dbg_state, ST_SYNC);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // read, two halves
        issue(32'h0000_1234, 32'h0, 4'h0, 2, acc(0, 20'h0091A, 2'b11, 0), acc(0, 20'h0091B, 2'b11, 0),
              32'hCAFEBEEF, 5, 0, 0, 1);
        // full write, rdata holds
        issue(32'h0000_0100, 32'h1122_3344, 4'hF, 2, acc(1, 20'h00080, 2'b11, 16'h3344),
              acc(1, 20'h00081, 2'b11, 16'h1122), 32'hCAFEBEEF, 5, 0, 0, 1);
        // HI-only write skips LO
        issue(32'h0000_0200, 32'hA5B6_C7D8, 4'b0100, 1, acc(1, 20'h00101, 2'b01, 16'hA5B6), '0,
              32'hCAFEBEEF, 3, 0, 0, 1);
        // LO-only write skips HI
        issue(32'h0000_0300, 32'h9999_5A5A, 4'b0011, 1, acc(1, 20'h00180, 2'b11, 16'h5A5A), '0,
              32'hCAFEBEEF, 3, 0, 0, 1);
        // slow controller
        ack_delay = 7;
        issue(32'h0000_4000, 32'h0, 4'h0, 2, acc(0, 20'h02000, 2'b11, 0), acc(0, 20'h02001, 2'b11, 0),
              32'h24681357, 17, 0, 0, 1);

        // reset while waiting on the HI half, ack lagging afterwards
        issue(32'h0000_4000, 32'h0, 4'h0, 2, acc(0, 20'h02000, 2'b11, 0), acc(0, 20'h02001, 2'b11, 0),
              32'h24681357, 17, 0, 0, 0);
        repeat (11) @(posedge clk);
        #1;
        chk("mid_state_wait", o_dbg_state, ST_WAIT);
        chk("mid_hi_addr", rv_addr, 20'h02001);
        ctl_ack_val = 1'b1;
        ctl_manual  = 1'b1;
        reset       = 1'b1;
        mem_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_acc_q.delete();
        exp_rsp_q.delete();
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("sync_req", rv_req, 0);
            chk("sync_state", o_dbg_state, ST_SYNC);
        end
        chk("post_rst_rdata", mem_rdata, 0);
        ctl_ack_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sync_to_idle", o_dbg_state, ST_IDLE);
        ctl_manual = 1'b0;
        ack_delay  = 1;
        issue(32'h0000_4000, 32'h0, 4'h0, 2, acc(0, 20'h02000, 2'b11, 0), acc(0, 20'h02001, 2'b11, 0),
              32'h24681357, 5, 0, 0, 1);

        // back-to-back reads with mem_valid held, last one at the top word with high bits set
        issue(32'h0000_0100, 32'h0, 4'h0, 2, acc(0, 20'h00080, 2'b11, 0), acc(0, 20'h00081, 2'b11, 0),
              32'h11223344, 5, 0, 1, 1);
        issue(32'h0000_0200, 32'h0, 4'h0, 2, acc(0, 20'h00100, 2'b11, 0), acc(0, 20'h00101, 2'b11, 0),
              32'h00B60000, 5, 1, 1, 1);
        issue(32'hFFFF_FFFC, 32'h0, 4'h0, 2, acc(0, 20'hFFFFE, 2'b11, 0), acc(0, 20'hFFFFF, 2'b11, 0),
              32'hF0F00F0F, 5, 1, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("acc_q_empty", 64'(exp_acc_q.size()), 0);
        chk("rsp_q_empty", 64'(exp_rsp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
